// File: rtl/pll_cen_pkg.sv
// pll_cen_pkg: shared state type, default width and channel slice helper for pll_cen_gen
package pll_cen_pkg;
    typedef enum logic {SETTLE, LOCKED} state_t;
    localparam int ACC_W_DEF = 16;
    function automatic int slice_lsb(input int ch, input int w);
        return ch * w;
    endfunction
endpackage

// File: rtl/pll_cen_acc.sv
// pll_cen_acc: one fractional accumulator channel producing a registered clock-enable
module pll_cen_acc #(
    parameter int ACC_W = 16
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             run,
    input  logic             clr,
    input  logic [ACC_W-1:0] num,
    input  logic [ACC_W-1:0] den,
    output logic             cen
);
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] rem;
    logic [ACC_W:0]   sum;
    logic             hit;
    assign sum = {1'b0, acc} + {1'b0, num};
    assign hit = sum >= {1'b0, den};
    assign rem = ACC_W'(sum - {1'b0, den});
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            cen <= 1'b0;
        end else if (!run) begin
            acc <= '0;
            cen <= 1'b0;
        end else begin
            cen <= hit;
            acc <= clr ? '0 : hit ? rem : sum[ACC_W-1:0];
        end
    end
endmodule

// File: rtl/pll_cen_gen.sv
// pll_cen_gen: multi-channel fractional clock-enable generator with settle/lock and runtime reconfig
// Define PLL_CEN_CLKOUT_EN to add per-channel divided clkout toggle outputs.
module pll_cen_gen
    import pll_cen_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ACC_W = ACC_W_DEF,
    parameter int LOCK_CYCLES = 64,
    parameter logic [NUM_CH*ACC_W-1:0] RST_NUM = {16'd1, 16'd1},
    parameter logic [NUM_CH*ACC_W-1:0] RST_DEN = {16'd2, 16'd8},
    localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_num,
    input  logic [ACC_W-1:0]  cfg_den,
    output logic              cfg_err,
    input  logic              sync_req,
    output logic [NUM_CH-1:0] cen,
    output logic              locked
`ifdef PLL_CEN_CLKOUT_EN
    ,
    output logic [NUM_CH-1:0] clkout
`endif
);
    localparam int CNT_W = $clog2(LOCK_CYCLES) + 1;
    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [NUM_CH*ACC_W-1:0] num_r;
    logic [NUM_CH*ACC_W-1:0] den_r;
    logic                    cfg_fit;
    logic                    cfg_ok;
    logic                    last;
    logic                    run;
    logic                    clr;
    assign locked    = state == LOCKED;
    assign cfg_ready = locked;
    assign cfg_fit   = cfg_den != '0 && cfg_num <= cfg_den && int'(cfg_ch) < NUM_CH;
    assign cfg_ok    = cfg_valid && locked && cfg_fit;
    assign last      = cnt == CNT_W'(LOCK_CYCLES - 1);
    // accumulators start on the final settle cycle so the first registered cen lands on locked cycle D-1
    assign run       = locked ? !cfg_ok : last;
    assign clr       = sync_req && locked;
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state   <= SETTLE;
            cnt     <= '0;
            cfg_err <= 1'b0;
            num_r   <= RST_NUM;
            den_r   <= RST_DEN;
        end else begin
            cfg_err <= cfg_valid && locked && !cfg_fit;
            if (!locked) begin
                cnt   <= last ? '0 : cnt + 1'b1;
                state <= last ? LOCKED : SETTLE;
            end else if (cfg_ok) begin
                state <= SETTLE;
                num_r[slice_lsb(int'(cfg_ch), ACC_W) +: ACC_W] <= cfg_num;
                den_r[slice_lsb(int'(cfg_ch), ACC_W) +: ACC_W] <= cfg_den;
            end
        end
    end
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pll_cen_acc #(.ACC_W(ACC_W)) u_acc (
            .refclk (refclk),
            .rst    (rst),
            .run    (run),
            .clr    (clr),
            .num    (num_r[slice_lsb(i, ACC_W) +: ACC_W]),
            .den    (den_r[slice_lsb(i, ACC_W) +: ACC_W]),
            .cen    (cen[i])
        );
    end
`ifdef PLL_CEN_CLKOUT_EN
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) clkout <= '0;
        else clkout <= locked ? clkout ^ cen : '0;
    end
`endif
endmodule

// File: tb/tb_pll_cen_gen.sv
// tb_pll_cen_gen: directed checks of lock timing, ratios, reconfig, reject, sync and reset for pll_cen_gen
module tb_pll_cen_gen;
    localparam int NC = 3;
    logic          refclk = 1'b0;
    logic          rst = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          sync_req = 1'b0;
    logic [1:0]    cfg_ch = '0;
    logic [15:0]   cfg_num = '0;
    logic [15:0]   cfg_den = '0;
    logic          cfg_ready;
    logic          cfg_err;
    logic          locked;
    logic [NC-1:0] cen;
`ifdef PLL_CEN_CLKOUT_EN
    logic [NC-1:0] clkout;
`endif
    int total = 0;
    int bad = 0;
    int pulses;
    always #5 refclk = ~refclk;
    pll_cen_gen #(
        .NUM_CH(NC),
        .ACC_W(16),
        .LOCK_CYCLES(64),
        .RST_NUM({16'd1, 16'd1, 16'd1}),
        .RST_DEN({16'd4, 16'd2, 16'd8})
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_num   (cfg_num),
        .cfg_den   (cfg_den),
        .cfg_err   (cfg_err),
        .sync_req  (sync_req),
        .cen       (cen),
        .locked    (locked)
`ifdef PLL_CEN_CLKOUT_EN
        ,
        .clkout    (clkout)
`endif
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge refclk);
        #1;
    endtask
    task automatic wait_lock(input string tag);
        int n = 0;
        while (!locked && n < 200) begin
            step();
            n++;
        end
        chk(tag, n, 64);
    endtask
    task automatic cfg(input logic [1:0] ch, input logic [15:0] num, input logic [15:0] den);
        cfg_ch = ch;
        cfg_num = num;
        cfg_den = den;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        chk("cfg_drop_locked", locked, 0);
        chk("cfg_settle_cen", cen, 0);
        wait_lock("relock_cycles");
    endtask
    function automatic logic ip(input int k, input int d);
        return k % d == d - 1;
    endfunction
    function automatic logic [2:0] rst_pat(input int k);
        return {ip(k, 4), ip(k, 2), ip(k, 8)};
    endfunction
    function automatic logic [2:0] frac_pat(input int k);
        return {ip(k, 4), ip(k, 2), (k % 8 == 2 || k % 8 == 5 || k % 8 == 7)};
    endfunction
    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1);
    end
    initial begin
        #1 rst = 1'b1;
        #2;
        chk("rst_cen", cen, 0);
        chk("rst_locked", locked, 0);
        chk("rst_ready", cfg_ready, 0);
        chk("rst_err", cfg_err, 0);
        step();
        step();
        rst = 1'b0;
        wait_lock("lock_after_reset");
        chk("ready_when_locked", cfg_ready, 1);
        for (int k = 0; k < 24; k++) begin
            chk("reset_pattern", cen, rst_pat(k));
            step();
        end
        // fractional 3/8 on ch0
        cfg(2'd0, 16'd3, 16'd8);
        pulses = 0;
        for (int k = 0; k < 80; k++) begin
            chk("frac_pattern", cen, frac_pat(k));
            pulses += int'(cen[0]);
            step();
        end
        chk("frac_pulses_80", pulses, 30);
        // rejected requests must not disturb the running pattern
        for (int k = 80; k < 96; k++) begin
            chk("rej_pattern", cen, frac_pat(k));
            chk("rej_locked", locked, 1);
            chk("rej_err", cfg_err, k == 81 || k == 83 || k == 85);
            cfg_valid = k == 80 || k == 82 || k == 84;
            cfg_ch = k == 84 ? 2'd3 : 2'd0;
            cfg_num = k == 80 ? 16'd9 : 16'd1;
            cfg_den = k == 82 ? 16'd0 : 16'd8;
            step();
        end
        cfg_valid = 1'b0;
        // sync at ch0 acc=5 realigns every channel
        cfg(2'd0, 16'd1, 16'd8);
        for (int k = 0; k < 21; k++) begin
            chk("sync_pattern", cen, k < 5 ? rst_pat(k) : {k % 4 == 1 && k >= 9, ip(k, 2), k == 13});
            sync_req = k == 4;
            step();
        end
        sync_req = 1'b0;
        cfg(2'd0, 16'd8, 16'd8);
        for (int k = 0; k < 16; k++) begin
            chk("full_rate", cen[0], 1);
            step();
        end
        // ch0 -> 0/8, then a second request held through the settle window
        cfg_ch = 2'd0;
        cfg_num = 16'd0;
        cfg_den = 16'd8;
        cfg_valid = 1'b1;
        step();
        cfg_ch = 2'd1;
        cfg_num = 16'd1;
        cfg_den = 16'd3;
        chk("hold_ready_low", cfg_ready, 0);
        wait_lock("hold_relock");
        chk("hold_accept_err", cfg_err, 0);
        step();
        cfg_valid = 1'b0;
        chk("hold_accepted", locked, 0);
        wait_lock("num0_relock");
        pulses = 0;
        for (int k = 0; k < 1000; k++) begin
            chk("num0_pattern", cen, {ip(k, 4), k % 3 == 2, 1'b0});
            pulses += int'(cen[0]);
            step();
        end
        chk("num0_pulses", pulses, 0);
        step();
        chk("pre_rst_cen", cen, 3'b010);
        #2 rst = 1'b1;
        #1;
        chk("midrst_cen", cen, 0);
        chk("midrst_locked", locked, 0);
        chk("midrst_ready", cfg_ready, 0);
        step();
        rst = 1'b0;
        wait_lock("lock_after_midrst");
        for (int k = 0; k < 40; k++) begin
            chk("restored_pattern", cen, rst_pat(k));
`ifdef PLL_CEN_CLKOUT_EN
            chk("clkout0", clkout[0], (k / 8) % 2);
`endif
            step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
